// File: rtl/cp_fifo_tracker.sv
// GP command FIFO tracker: write/read pointers, distance, fetch-request FSM,
// watermark/breakpoint interrupt pulses and idle status for the CP register block.
module cp_fifo_tracker #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] FIFOBase,
  input  logic [31:0] FIFOEnd,
  input  logic [31:0] FIFOHighWatermark,
  input  logic [31:0] FIFOLowWatermark,
  input  logic [31:0] FIFOBreakpoint,
  input  logic        FIFONewBase,
  input  logic        EnGPFIFO,
  input  logic        EnGPLink,
  input  logic        EnBP,
  input  logic        EnFIFOOverflow,
  input  logic        EnFIFOUnderflow,
  input  logic        WrLine,
  output logic        ReqValid,
  input  logic        ReqReady,
  output logic [31:0] ReqAddress,
  input  logic        RspDone,
  input  logic        ParserIdle,
  output logic [31:0] FIFOWritePointer,
  output logic [31:0] FIFOReadPointer,
  output logic [31:0] FIFORWDistance,
  output logic        IntFIFOverflow,
  output logic        IntFIFOUnderflow,
  output logic        IntBP,
  output logic        StatGPReadIdle,
  output logic        StatGPIdle,
  output logic        WrDropped
);

  localparam logic [31:0] LINE = 32'd32;
  localparam int OW = 4;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HALT} state_t;

  state_t         state_reg, state_next;
  logic [31:0]    wp_reg, rp_reg, dist_reg, dist_next;
  logic [OW-1:0]  outst_reg;
  logic           req_valid_reg, req_valid_next;
  logic [31:0]    req_addr_reg, req_addr_next;
  logic           int_bp_reg, int_bp_next;
  logic           int_over_reg, int_under_reg, wr_dropped_reg;
  logic           above_high_reg, below_low_reg;

  logic [31:0] base, fifo_end, high_wm, low_wm, bp_addr, fifo_size;
  logic        full, wr_accept, handshake, rsp_accept, bp_hit, start_req;
  logic        unused_cfg_bits;

  assign base      = {FIFOBase[31:5], 5'd0};
  assign fifo_end  = {FIFOEnd[31:5], 5'd0};
  assign high_wm   = {FIFOHighWatermark[31:5], 5'd0};
  assign low_wm    = {FIFOLowWatermark[31:5], 5'd0};
  assign bp_addr   = {FIFOBreakpoint[31:5], 5'd0};
  assign fifo_size = fifo_end - base + LINE;
  assign unused_cfg_bits = ^{FIFOBase[4:0], FIFOEnd[4:0], FIFOHighWatermark[4:0],
                             FIFOLowWatermark[4:0], FIFOBreakpoint[4:0]};

  // FIFOEnd is the last valid line, so wrap once the pointer reaches it.
  function automatic logic [31:0] advance(input logic [31:0] p, input logic [31:0] b,
                                          input logic [31:0] e);
    return (p >= e) ? b : p + LINE;
  endfunction

  assign full       = (dist_reg == fifo_size);
  assign wr_accept  = WrLine & ~full & ~FIFONewBase;
  assign handshake  = req_valid_reg & ReqReady & ~FIFONewBase;
  assign rsp_accept = RspDone & (outst_reg != '0);
  assign bp_hit     = EnBP & (dist_reg != '0) & (rp_reg == bp_addr);
  assign start_req  = EnGPFIFO & (dist_reg != '0) &
                      (outst_reg < OW'(MAX_OUTSTANDING)) & ~bp_hit;

  always_comb begin
    dist_next = dist_reg;
    if (wr_accept & ~handshake)
      dist_next = dist_reg + LINE;
    else if (handshake & ~wr_accept)
      dist_next = dist_reg - LINE;
  end

  always_ff @(posedge clk) begin
    if (reset)
      state_reg <= S_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (FIFONewBase) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (bp_hit)
            state_next = S_HALT;
          else if (start_req)
            state_next = S_REQ;
        end
        S_REQ:   if (ReqReady) state_next = S_IDLE;
        S_HALT:  if (!EnBP) state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Request outputs are computed from the next state so they leave on flops.
  always_comb begin
    req_valid_next = (state_next == S_REQ);
    req_addr_next  = req_addr_reg;
    int_bp_next    = 1'b0;
    if (state_reg == S_IDLE && !FIFONewBase) begin
      if (bp_hit)
        int_bp_next = 1'b1;
      else if (start_req)
        req_addr_next = rp_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_valid_reg <= 1'b0;
      req_addr_reg  <= '0;
      int_bp_reg    <= 1'b0;
    end else begin
      req_valid_reg <= req_valid_next;
      req_addr_reg  <= req_addr_next;
      int_bp_reg    <= int_bp_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_reg         <= '0;
      rp_reg         <= '0;
      dist_reg       <= '0;
      outst_reg      <= '0;
      wr_dropped_reg <= 1'b0;
      above_high_reg <= 1'b0;
      below_low_reg  <= 1'b0;
      int_over_reg   <= 1'b0;
      int_under_reg  <= 1'b0;
    end else begin
      if (FIFONewBase) begin
        wp_reg   <= base;
        rp_reg   <= base;
        dist_reg <= '0;
      end else begin
        if (wr_accept) wp_reg <= advance(wp_reg, base, fifo_end);
        if (handshake) rp_reg <= advance(rp_reg, base, fifo_end);
        dist_reg <= dist_next;
      end
      // Late responses after a rebase still retire their outstanding slot.
      outst_reg      <= outst_reg + {{(OW-1){1'b0}}, handshake}
                                  - {{(OW-1){1'b0}}, rsp_accept};
      wr_dropped_reg <= WrLine & full & ~FIFONewBase;
      above_high_reg <= (dist_reg > high_wm);
      below_low_reg  <= (dist_reg < low_wm);
      int_over_reg   <= EnGPLink & EnFIFOOverflow & (dist_reg > high_wm) & ~above_high_reg;
      int_under_reg  <= EnGPLink & EnFIFOUnderflow & (dist_reg < low_wm) & ~below_low_reg;
    end
  end

  assign ReqValid         = req_valid_reg;
  assign ReqAddress       = req_addr_reg;
  assign FIFOWritePointer = wp_reg;
  assign FIFOReadPointer  = rp_reg;
  assign FIFORWDistance   = dist_reg;
  assign IntFIFOverflow   = int_over_reg;
  assign IntFIFOUnderflow = int_under_reg;
  assign IntBP            = int_bp_reg;
  assign WrDropped        = wr_dropped_reg;
  assign StatGPReadIdle   = (outst_reg == '0) &
                            ((dist_reg == '0) | ~EnGPFIFO | (state_reg == S_HALT));
  assign StatGPIdle       = StatGPReadIdle & ParserIdle;

endmodule

// File: tb/tb_cp_fifo_tracker.sv
// Bench for cp_fifo_tracker: directed scenarios plus randomized traffic, all
// checked every cycle against a behavioural FIFO model.
module tb_cp_fifo_tracker;

  localparam int MAX_OUT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] FIFOBase, FIFOEnd, FIFOHighWatermark, FIFOLowWatermark, FIFOBreakpoint;
  logic        FIFONewBase, EnGPFIFO, EnGPLink, EnBP, EnFIFOOverflow, EnFIFOUnderflow;
  logic        WrLine, ReqReady, RspDone, ParserIdle;
  logic        ReqValid, IntFIFOverflow, IntFIFOUnderflow, IntBP;
  logic        StatGPReadIdle, StatGPIdle, WrDropped;
  logic [31:0] ReqAddress, FIFOWritePointer, FIFOReadPointer, FIFORWDistance;

  cp_fifo_tracker #(.MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk(clk), .reset(reset),
    .FIFOBase(FIFOBase), .FIFOEnd(FIFOEnd),
    .FIFOHighWatermark(FIFOHighWatermark), .FIFOLowWatermark(FIFOLowWatermark),
    .FIFOBreakpoint(FIFOBreakpoint), .FIFONewBase(FIFONewBase),
    .EnGPFIFO(EnGPFIFO), .EnGPLink(EnGPLink), .EnBP(EnBP),
    .EnFIFOOverflow(EnFIFOOverflow), .EnFIFOUnderflow(EnFIFOUnderflow),
    .WrLine(WrLine), .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqAddress(ReqAddress),
    .RspDone(RspDone), .ParserIdle(ParserIdle),
    .FIFOWritePointer(FIFOWritePointer), .FIFOReadPointer(FIFOReadPointer),
    .FIFORWDistance(FIFORWDistance), .IntFIFOverflow(IntFIFOverflow),
    .IntFIFOUnderflow(IntFIFOUnderflow), .IntBP(IntBP),
    .StatGPReadIdle(StatGPReadIdle), .StatGPIdle(StatGPIdle), .WrDropped(WrDropped)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural view of the FIFO
  logic [31:0] m_wp, m_rp, m_dist, m_addr;
  int          m_out;
  bit          m_fetching, m_halted, m_above, m_below;
  bit          m_ovf, m_udf, m_bp, m_drop;

  logic [31:0] req_log[$];
  int          cnt_ovf, cnt_bp, cnt_drop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] adv(input logic [31:0] p, input logic [31:0] b,
                                      input logic [31:0] e);
    return (p >= e) ? b : p + 32'd32;
  endfunction

  task automatic model_step();
    logic [31:0] b, e, sz, hw, lw, bpa;
    bit full, wacc, hs, rsp_ok, idle, bphit, start;
    if (reset) begin
      m_wp = '0; m_rp = '0; m_dist = '0; m_addr = '0; m_out = 0;
      m_fetching = 0; m_halted = 0; m_above = 0; m_below = 0;
      m_ovf = 0; m_udf = 0; m_bp = 0; m_drop = 0;
      return;
    end
    b   = FIFOBase & ~32'h1f;
    e   = FIFOEnd & ~32'h1f;
    hw  = FIFOHighWatermark & ~32'h1f;
    lw  = FIFOLowWatermark & ~32'h1f;
    bpa = FIFOBreakpoint & ~32'h1f;
    sz  = e - b + 32'd32;
    full   = (m_dist == sz);
    hs     = m_fetching && ReqReady;
    rsp_ok = RspDone && (m_out > 0);
    idle   = !m_fetching && !m_halted;
    bphit  = EnBP && (m_dist != 0) && (m_rp == bpa);
    start  = EnGPFIFO && (m_dist != 0) && (m_out < MAX_OUT) && !bphit;
    m_ovf   = EnGPLink && EnFIFOOverflow && (m_dist > hw) && !m_above;
    m_udf   = EnGPLink && EnFIFOUnderflow && (m_dist < lw) && !m_below;
    m_above = (m_dist > hw);
    m_below = (m_dist < lw);
    m_bp    = idle && bphit && !FIFONewBase;
    if (rsp_ok) m_out--;
    if (FIFONewBase) begin
      m_wp = b; m_rp = b; m_dist = '0;
      m_fetching = 0; m_halted = 0; m_drop = 0;
    end else begin
      m_drop = WrLine && full;
      wacc   = WrLine && !full;
      if (m_fetching) begin
        if (ReqReady) m_fetching = 0;
      end else if (m_halted) begin
        if (!EnBP) m_halted = 0;
      end else if (bphit) begin
        m_halted = 1;
      end else if (start) begin
        m_fetching = 1;
        m_addr = m_rp;
      end
      if (hs) begin
        m_rp = adv(m_rp, b, e);
        m_out++;
        m_dist -= 32'd32;
      end
      if (wacc) begin
        m_wp = adv(m_wp, b, e);
        m_dist += 32'd32;
      end
    end
  endtask

  task automatic compare_all();
    bit exp_read_idle;
    exp_read_idle = (m_out == 0) && ((m_dist == 0) || !EnGPFIFO || m_halted);
    chk("wp", FIFOWritePointer, m_wp);
    chk("rp", FIFOReadPointer, m_rp);
    chk("dist", FIFORWDistance, m_dist);
    chk("req_valid", ReqValid, m_fetching);
    chk("req_addr", ReqAddress, m_addr);
    chk("int_ovf", IntFIFOverflow, m_ovf);
    chk("int_udf", IntFIFOUnderflow, m_udf);
    chk("int_bp", IntBP, m_bp);
    chk("wr_dropped", WrDropped, m_drop);
    chk("read_idle", StatGPReadIdle, exp_read_idle);
    chk("gp_idle", StatGPIdle, exp_read_idle && ParserIdle);
  endtask

  // Inputs change only around the falling edge; one model step per rising edge.
  task automatic tick();
    if (ReqValid && ReqReady && !FIFONewBase && !reset) req_log.push_back(ReqAddress);
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    if (IntFIFOverflow) cnt_ovf++;
    if (IntBP) cnt_bp++;
    if (WrDropped) cnt_drop++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain(input string name);
    bit done;
    done = 0;
    EnGPFIFO = 1; ReqReady = 1;
    for (int i = 0; i < 300 && !done; i++) begin
      RspDone = (i % 2 == 0);
      tick();
      done = StatGPReadIdle && (FIFORWDistance == 0);
    end
    RspDone = 0;
    chk(name, {31'b0, done}, 32'd1);
  endtask

  task automatic write_lines(input int n);
    WrLine = 1;
    ticks(n);
    WrLine = 0;
  endtask

  initial begin
    reset = 1; FIFOBase = 32'h1000; FIFOEnd = 32'h10E0;
    FIFOHighWatermark = 32'hFFFF_FFE0; FIFOLowWatermark = 0; FIFOBreakpoint = 0;
    FIFONewBase = 0; EnGPFIFO = 0; EnGPLink = 0; EnBP = 0;
    EnFIFOOverflow = 0; EnFIFOUnderflow = 0;
    WrLine = 0; ReqReady = 0; RspDone = 0; ParserIdle = 1;
    cnt_ovf = 0; cnt_bp = 0; cnt_drop = 0;
    ticks(3);
    reset = 0;
    tick();
    chk("reset_read_idle", StatGPReadIdle, 32'd1);
    chk("reset_wp", FIFOWritePointer, 32'h0);
    chk("reset_req_valid", ReqValid, 32'd0);

    // Fill the 8-line FIFO, then overflow it by one write
    FIFONewBase = 1; tick(); FIFONewBase = 0;
    write_lines(8);
    chk("fill_wp_wrap", FIFOWritePointer, 32'h1000);
    chk("fill_dist", FIFORWDistance, 32'h100);
    write_lines(1);
    chk("drop_count", cnt_drop, 32'd1);
    chk("drop_dist", FIFORWDistance, 32'h100);

    // Fetch limit: only MAX_OUT requests without responses
    req_log.delete();
    EnGPFIFO = 1; ReqReady = 1;
    ticks(20);
    chk("limit_count", req_log.size(), 32'd4);
    for (int i = 0; i < 4 && i < req_log.size(); i++)
      chk("limit_addr", req_log[i], 32'h1000 + 32'h20 * i);
    chk("limit_req_valid", ReqValid, 32'd0);
    req_log.delete();
    drain("drain_fill");
    chk("resume_count", req_log.size(), 32'd4);
    if (req_log.size() == 4) chk("resume_last_addr", req_log[3], 32'h10E0);
    chk("resume_rp_wrap", FIFOReadPointer, 32'h1000);

    // High watermark: single overflow pulse
    EnGPFIFO = 0; FIFOHighWatermark = 32'h80; EnGPLink = 1; EnFIFOOverflow = 1;
    cnt_ovf = 0;
    write_lines(8);
    ticks(3);
    chk("ovf_count", cnt_ovf, 32'd1);
    EnFIFOOverflow = 0; FIFOHighWatermark = 32'hFFFF_FFE0;
    drain("drain_ovf");

    // Breakpoint halt and resume
    EnGPFIFO = 0;
    write_lines(4);
    FIFOBreakpoint = 32'h1040; EnBP = 1; cnt_bp = 0;
    req_log.delete();
    EnGPFIFO = 1; ReqReady = 1; RspDone = 1;
    ticks(15);
    chk("bp_req_count", req_log.size(), 32'd2);
    if (req_log.size() >= 2) chk("bp_req1", req_log[1], 32'h1020);
    chk("bp_pulses", cnt_bp, 32'd1);
    chk("bp_rp", FIFOReadPointer, 32'h1040);
    EnBP = 0;
    ticks(10);
    if (req_log.size() >= 3) chk("bp_resume_addr", req_log[2], 32'h1040);
    else chk("bp_resume_count", req_log.size(), 32'd3);
    RspDone = 0;
    drain("drain_bp");

    // Rebase while a request is stalled
    EnGPFIFO = 0;
    write_lines(2);
    EnGPFIFO = 1; ReqReady = 0;
    ticks(3);
    chk("stall_req_valid", ReqValid, 32'd1);
    FIFOBase = 32'h2000; FIFOEnd = 32'h20E0; FIFONewBase = 1; WrLine = 1;
    tick();
    FIFONewBase = 0; WrLine = 0;
    chk("rebase_req_valid", ReqValid, 32'd0);
    chk("rebase_wp", FIFOWritePointer, 32'h2000);
    chk("rebase_rp", FIFOReadPointer, 32'h2000);
    chk("rebase_dist", FIFORWDistance, 32'h0);
    drain("drain_rebase");

    // Write and handshake in the same cycle
    EnGPFIFO = 0;
    write_lines(2);
    EnGPFIFO = 1; ReqReady = 0;
    ticks(2);
    chk("simul_req_valid", ReqValid, 32'd1);
    WrLine = 1; ReqReady = 1;
    tick();
    WrLine = 0; ReqReady = 0;
    chk("simul_dist", FIFORWDistance, 32'h40);
    chk("simul_wp", FIFOWritePointer, 32'h2060);
    chk("simul_rp", FIFOReadPointer, 32'h2020);
    drain("drain_simul");

    // Randomized traffic
    FIFOBase = 32'h3000; FIFOEnd = 32'h30E0; FIFONewBase = 1; tick(); FIFONewBase = 0;
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom % 400 == 0);
      FIFONewBase = ($urandom % 100 == 0);
      if (FIFONewBase) begin
        FIFOBase = 32'h3000 + 32'h1000 * $urandom_range(0, 3) + $urandom_range(0, 31);
        FIFOEnd  = (FIFOBase & ~32'h1f) + 32'h20 * $urandom_range(0, 15) + $urandom_range(0, 31);
      end
      WrLine     = $urandom % 2;
      ReqReady   = ($urandom % 10) < 6;
      RspDone    = ($urandom % 10) < 4;
      ParserIdle = $urandom % 2;
      if ($urandom % 20 == 0) EnGPFIFO = ~EnGPFIFO;
      if ($urandom % 30 == 0) begin
        EnBP = ~EnBP;
        FIFOBreakpoint = (FIFOBase & ~32'h1f) + 32'h20 * $urandom_range(0, 15) + $urandom_range(0, 31);
      end
      if ($urandom % 50 == 0) begin
        FIFOHighWatermark = 32'h20 * $urandom_range(0, 8) + $urandom_range(0, 31);
        FIFOLowWatermark  = 32'h20 * $urandom_range(0, 8) + $urandom_range(0, 31);
      end
      if ($urandom % 25 == 0) EnGPLink = ~EnGPLink;
      if ($urandom % 25 == 0) EnFIFOOverflow = ~EnFIFOOverflow;
      if ($urandom % 25 == 0) EnFIFOUnderflow = ~EnFIFOUnderflow;
      tick();
    end
    reset = 0; FIFONewBase = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
